// File: rtl/program_counter_pkg.sv
// Shared CPU constants for the program counter.
// Holds the datapath address width and the reset vector.
package program_counter_pkg;

    localparam int PC_ADDR_W = 16;
    localparam logic [PC_ADDR_W-1:0] PC_RESET_VEC = 16'h0000;

    typedef logic [PC_ADDR_W-1:0] pc_addr_t;

endpackage

// File: rtl/program_counter_incrementer.sv
// Combinational +1 for the program counter.
// The sum is truncated to W bits, so all-ones wraps to zero.
module program_counter_incrementer #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] next_value
);

    assign next_value = value + W'(1);

endmodule

// File: rtl/program_counter.sv
// Program counter for the 8-bit CPU datapath.
// Each cycle the PC resets, loads a target, increments, or holds, in that priority.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int ADDR_W = PC_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              loadPC,
    input  logic              incPC,
    input  logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] execadd
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus_one;

    program_counter_incrementer #(
        .W(ADDR_W)
    ) u_incrementer (
        .value      (pc),
        .next_value (pc_plus_one)
    );

    // address is only read when loadPC is set, so X on it otherwise cannot leak in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_VEC;
        end else if (loadPC) begin
            pc <= address;
        end else if (incPC) begin
            pc <= pc_plus_one;
        end
    end

    assign execadd = pc;

`ifdef SIMULATION
    logic seen_reset;
    logic wrap_pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seen_reset <= 1'b1;
        end
        wrap_pending <= rst_n && !loadPC && incPC && (pc == '1);
        if (seen_reset === 1'b1) begin
            assert (!$isunknown(execadd))
                else $error("execadd is unknown after reset");
        end
        if (wrap_pending) begin
            assert (execadd == '0)
                else $error("increment from all-ones did not wrap to zero");
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed literal cases plus a
// randomized run compared every cycle against an arithmetic model.
module tb_program_counter;

    logic        clk;
    logic        rst_n;
    logic        loadPC;
    logic        incPC;
    logic [15:0] address;
    logic [15:0] execadd;

    int tests_run  = 0;
    int fail_count = 0;

    int          model_pc    = 0;
    bit          model_valid = 1'b0;

    program_counter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .loadPC  (loadPC),
        .incPC   (incPC),
        .address (address),
        .execadd (execadd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what the PC must hold after each edge, from the priority rules
    always @(posedge clk) begin
        if (!rst_n) begin
            model_pc    = 0;
            model_valid = 1'b1;
        end else if (loadPC) begin
            model_pc = int'(address);
        end else if (incPC) begin
            model_pc = (model_pc + 1) % 65536;
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] expected);
        tests_run++;
        if (execadd !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: execadd=%h expected=%h at %0t", name, execadd, expected, $time);
        end
    endtask

    // Compare every cycle once the model has seen a reset
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("model", 16'(model_pc));
        end
    end

    task automatic applyStimulus(input logic r, input logic l, input logic i, input logic [15:0] a);
        @(negedge clk);
        rst_n   = r;
        loadPC  = l;
        incPC   = i;
        address = a;
    endtask

    task automatic step(input string name, input logic r, input logic l, input logic i,
                        input logic [15:0] a, input logic [15:0] expected);
        applyStimulus(r, l, i, a);
        @(posedge clk);
        #1;
        checkOutput(name, expected);
    endtask

    initial begin
        rst_n   = 1'b0;
        loadPC  = 1'b1;
        incPC   = 1'b0;
        address = 16'hAAAA;

        step("reset_0",       1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h0000);
        step("reset_1",       1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h0000);
        step("reset_hold_0",  1'b1, 1'b0, 1'b0, 16'hAAAA, 16'h0000);
        step("reset_hold_1",  1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000);

        step("load_1234",     1'b1, 1'b1, 1'b0, 16'h1234, 16'h1234);
        step("hold_1234",     1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h1234);
        step("inc_1235",      1'b1, 1'b0, 1'b1, 16'h0000, 16'h1235);
        step("inc_1236",      1'b1, 1'b0, 1'b1, 16'h0000, 16'h1236);

        step("reload_5678",   1'b1, 1'b1, 1'b0, 16'h5678, 16'h5678);
        step("reload_5679",   1'b1, 1'b0, 1'b1, 16'h1111, 16'h5679);
        step("reload_567A",   1'b1, 1'b0, 1'b1, 16'h2222, 16'h567A);

        step("priority_00F0", 1'b1, 1'b1, 1'b1, 16'h00F0, 16'h00F0);

        step("wrap_load",     1'b1, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE);
        step("wrap_FFFF",     1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFF);
        step("wrap_0000",     1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step("wrap_0001",     1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001);

        step("midrst_load",   1'b1, 1'b1, 1'b0, 16'h0010, 16'h0010);
        step("midrst_reset",  1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        step("midrst_resume", 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001);

        step("xaddr_hold",    1'b1, 1'b0, 1'b0, 16'hxxxx, 16'h0001);
        step("xaddr_inc",     1'b1, 1'b0, 1'b1, 16'hxxxx, 16'h0002);

        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        l;
            logic        i;
            logic [15:0] a;
            r = ($urandom_range(0, 31) != 0);
            l = ($urandom_range(0, 4) == 0);
            i = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                a = 16'hFFFF - 16'($urandom_range(0, 3));
            end else begin
                a = 16'($urandom);
            end
            applyStimulus(r, l, i, a);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/program_counter.md
# program_counter

16-bit program counter for the 8-bit microprocessor datapath. It holds the address of the instruction being fetched and drives it onto `execadd` for the memory/fetch stage. Each clock edge it either loads a jump/branch target from `address`, increments by one, or holds. The control unit drives `loadPC` and `incPC`.

## Interface
Parameters:
- `ADDR_W`, default 16: counter and address width in bits.
- `RESET_VEC`, default 16'h0000: value loaded on reset.

Ports:
- `clk` input 1: single system clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `loadPC` input 1: load `address` into the counter.
- `incPC` input 1: increment the counter by 1.
- `address` input ADDR_W: jump/branch target; used only when `loadPC`=1.
- `execadd` output ADDR_W: current PC value, driven directly from the PC register.

## Operation
- The PC register is `ADDR_W` bits wide. `execadd` always equals the register value, with no combinational path from the inputs.
- Rising edge of `clk`, in priority order:
  1. `rst_n`=0: PC <= `RESET_VEC`.
  2. `loadPC`=1: PC <= `address`. This applies whatever the value of `incPC`, so load beats increment.
  3. `incPC`=1: PC <= PC + 1, modulo 2^ADDR_W.
  4. Otherwise: PC holds.
- Wrap-around: 16'hFFFF with `incPC`=1 becomes 16'h0000. No overflow flag and no saturation.
- Reset value of `execadd` is `RESET_VEC` (16'h0000 by default).
- X or Z on `address` while `loadPC`=0 must not affect the PC.

## Timing
- Latency is 1 cycle. A command sampled at rising edge N is visible on `execadd` immediately after edge N and stays stable until edge N+1.
- Inputs must be stable around the rising edge. The control unit changes them on the falling edge.
- There is no handshake. Commands are level-sensitive, and each cycle they are asserted counts as one action:
  - `incPC` held high for k cycles advances the PC by k.
  - `loadPC` held high reloads `address` every cycle.
- Reset asserted mid-sequence takes effect at the next rising edge and discards any pending load or increment.
- Load and increment asserted in the same cycle: the PC takes `address`. There is no "load then increment".

## Structure
- Shared CPU package holds:
  - address width constant (16);
  - reset vector constant (16'h0000).
- An optional `pc_incrementer` sub-module (combinational `ADDR_W`-bit +1 with wrap) is natural. A plain inline adder is equally acceptable.
- The block is a single `always` block on `posedge clk`.
- Include assertions, active only under a simulation define:
  - `execadd` is never X after the first reset;
  - increment wraps correctly at all-ones.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `loadPC`=1 and `address`=16'hAAAA, then release -> `execadd`=16'h0000 and holds while `loadPC`=`incPC`=0.
- Load/hold/increment: load 16'h1234 -> 16'h1234; hold 1 cycle -> 16'h1234; `incPC` 2 cycles -> 16'h1235, then 16'h1236.
- Reload mid-sequence: load 16'h5678, then `incPC` 2 cycles -> 16'h5678, 16'h5679, 16'h567A.
- Priority: `loadPC`=1 and `incPC`=1 with `address`=16'h00F0 -> 16'h00F0, not 16'h00F1.
- Wrap: load 16'hFFFE, then `incPC` 3 cycles -> 16'hFFFF, 16'h0000, 16'h0001.
- Reset mid-increment: `incPC` held high from 16'h0010, `rst_n` pulsed low for 1 cycle -> 16'h0000 on that edge, then 16'h0001 on the next edge.
